// File: rtl/path_arb_pkg.sv
// Shared FSM state type and default configuration constants for path_arbiter.
package path_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_BURST   = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/path_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// (last + 1) mod NREQ with wrap-around.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    int unsigned idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // Offset 1..NREQ so the previous winner is considered last.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/path_arbiter.sv
// Round-robin burst arbiter for a shared downstream path.
// Optional starvation watchdog enabled by defining PATH_ARB_WATCHDOG_EN.
module path_arbiter
    import path_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned BURST   = DEF_BURST,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    ready_i,
    input  logic                    flush_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    busy_o,
    output logic [NREQ-1:0]         starve_o
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(BURST + 1);

    if (NREQ < 2 || NREQ > 16 || BURST < 1 || BURST > 255 || TIMEOUT < 1) begin : g_bad_cfg
        $error("path_arbiter: parameter out of range");
    end

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            burst_done;
    logic            hold;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req_i),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // cnt_q counts completed grant cycles; the current cycle is the last when it hits BURST-1.
    assign burst_done = (cnt_q == CW'(BURST - 1));
    assign hold       = req_i[owner_q] && !burst_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            last_d  = IW'(NREQ - 1);
            cnt_d   = '0;
        end else if (state_q == GRANT && ready_i && hold) begin
            cnt_d = cnt_q + 1'b1;
        end else if (ready_i && pick_valid) begin
            // New grant from IDLE or direct hand-off (possibly to the same owner).
            state_d         = GRANT;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            owner_d         = pick_idx;
            last_d          = pick_idx;
            cnt_d           = '0;
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q == GRANT);

`ifdef PATH_ARB_WATCHDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0]   wait_q [NREQ];
    logic [NREQ-1:0] starve_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                wait_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_i[i] && !gnt_q[i]) begin
                    if (wait_q[i] != WW'(TIMEOUT)) begin
                        wait_q[i] <= wait_q[i] + 1'b1;
                    end
                    if (wait_q[i] >= WW'(TIMEOUT - 1)) begin
                        starve_q[i] <= 1'b1;
                    end
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end

    assign starve_o = starve_q;
`else
    assign starve_o = '0;
`endif

endmodule

// File: tb/tb_path_arbiter.sv
// Self-checking bench for path_arbiter (NREQ=4, BURST=4, TIMEOUT=8).
module tb_path_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_i;
    logic       ready_i;
    logic       flush_i;
    logic [3:0] gnt_o;
    logic [1:0] owner_o;
    logic       busy_o;
    logic [3:0] starve_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [3:0] sb [$];

    always #5 clk = ~clk;

    path_arbiter #(
        .NREQ    (4),
        .BURST   (4),
        .TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .ready_i  (ready_i),
        .flush_i  (flush_i),
        .gnt_o    (gnt_o),
        .owner_o  (owner_o),
        .busy_o   (busy_o),
        .starve_o (starve_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] owner_of(input logic [3:0] g);
        logic [1:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) o = 2'(i);
        end
        return o;
    endfunction

    // Drive one cycle of stimulus and queue the grant expected after the next edge.
    task automatic cyc(input logic [3:0] req, input logic rdy, input logic fl, input logic [3:0] exp);
        @(negedge clk);
        req_i   = req;
        ready_i = rdy;
        flush_i = fl;
        sb.push_back(exp);
    endtask

    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("gnt", 32'(gnt_o), 32'(e));
            chk("busy", 32'(busy_o), 32'(|e));
            chk("owner", 32'(owner_o), 32'(owner_of(e)));
        end
        chk("onehot0", 32'($onehot0(gnt_o)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] exp_starve;
`ifdef PATH_ARB_WATCHDOG_EN
        exp_starve = 4'b0001;
`else
        exp_starve = 4'b0000;
`endif
        rst_n   = 1'b0;
        req_i   = 4'b1111;
        ready_i = 1'b1;
        flush_i = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_starve", 32'(starve_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt_o), 32'd0);
        @(negedge clk);
        req_i = 4'b0000;
        rst_n = 1'b1;

        // 1010 from reset: requester 1 then 3, each for BURST cycles, no gap
        repeat (4) cyc(4'b1010, 1, 0, 4'b0010);
        repeat (4) cyc(4'b1010, 1, 0, 4'b1000);
        cyc(4'b1010, 1, 0, 4'b0010);
        cyc(4'b0000, 1, 1, 4'b0000);
        cyc(4'b0000, 1, 0, 4'b0000);

        // All requesting: rotation 0,1,2,3,0
        for (int r = 0; r < 5; r++) begin
            logic [3:0] g;
            g = 4'b0001 << (r % 4);
            repeat (4) cyc(4'b1111, 1, 0, g);
        end
        cyc(4'b0000, 1, 1, 4'b0000);
        cyc(4'b0000, 1, 0, 4'b0000);

        // Lone requester re-granted without a bubble
        repeat (10) cyc(4'b0100, 1, 0, 4'b0100);
        cyc(4'b0000, 1, 1, 4'b0000);
        cyc(4'b0000, 1, 0, 4'b0000);

        // ready drop mid-grant, then resume from last winner
        cyc(4'b0010, 1, 0, 4'b0010);
        cyc(4'b0010, 0, 0, 4'b0000);
        cyc(4'b0011, 0, 0, 4'b0000);
        cyc(4'b0011, 1, 0, 4'b0001);
        cyc(4'b0000, 1, 0, 4'b0000);

        // Flush mid-grant to requester 3
        cyc(4'b1000, 1, 0, 4'b1000);
        cyc(4'b1001, 1, 0, 4'b1000);
        cyc(4'b1001, 1, 1, 4'b0000);
        cyc(4'b1001, 1, 0, 4'b0001);

        // Asynchronous reset mid-grant
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_owner", 32'(owner_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_gnt", 32'(gnt_o), 32'd0);
        @(negedge clk);
        req_i   = 4'b0000;
        ready_i = 1'b0;
        rst_n   = 1'b1;

        // Starvation watchdog
        repeat (7) cyc(4'b0001, 0, 0, 4'b0000);
        @(negedge clk);
        chk("starve_pre", 32'(starve_o), 32'd0);
        cyc(4'b0001, 0, 0, 4'b0000);
        @(negedge clk);
        chk("starve_set", 32'(starve_o), 32'(exp_starve));
        repeat (2) cyc(4'b0000, 0, 0, 4'b0000);
        @(negedge clk);
        chk("starve_sticky", 32'(starve_o), 32'(exp_starve));

        // After reset the search starts at requester 0
        cyc(4'b1001, 1, 0, 4'b0001);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/path_arbiter.md
PATH_ARBITER -- requirements
Module: path_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of path requesters (2..16).
REQ-002 SHALL have parameter BURST, default 4, max consecutive grant cycles per owner (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 64, starvation threshold in cycles (used only under PATH_ARB_WATCHDOG_EN).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_i, input, NREQ, per-path request (req_o of each path).
REQ-007 SHALL have port ready_i, input, 1, shared downstream resource can accept this cycle.
REQ-008 SHALL have port flush_i, input, 1, synchronous abort of current grant.
REQ-009 SHALL have port gnt_o, output, NREQ, registered one-hot grant (gnt_i of each path).
REQ-010 SHALL have port owner_o, output, $clog2(NREQ), index of current owner, 0 when idle.
REQ-011 SHALL have port busy_o, output, 1, high in GRANT state.
REQ-012 SHALL have port starve_o, output, NREQ, sticky per-requester starvation flag.

Function
REQ-013 SHALL implement FSM with states IDLE and GRANT; busy_o = (state == GRANT).
REQ-014 SHALL in IDLE with ready_i=1 and |req_i select the first set req_i bit searching from (last_winner+1) mod NREQ upward with wrap, enter GRANT, and assert that gnt_o bit the next cycle (1-cycle latency).
REQ-015 SHALL in IDLE with ready_i=0 or req_i=0 remain in IDLE with gnt_o=0.
REQ-016 SHALL hold gnt_o to the owner in GRANT while owner req_i=1, ready_i=1, and burst count < BURST.
REQ-017 SHALL count granted cycles in a counter of width $clog2(BURST+1), cleared on each new grant, including a re-grant to the same owner.
REQ-018 SHALL on release (owner req_i=0 or count reached BURST) with ready_i=1 and other or same requests pending hand off directly to the round-robin winner without an idle cycle; with no requests pending, return to IDLE with gnt_o=0.
REQ-019 SHALL on ready_i=0 in GRANT drop gnt_o to 0 next cycle and return to IDLE, preserving last_winner.
REQ-020 SHALL ensure gnt_o is always zero or one-hot; never two bits set.
REQ-021 SHALL update last_winner only when a grant is issued.
REQ-022 SHALL on flush_i=1 (priority over all other inputs) force IDLE, gnt_o=0, count=0, last_winner=NREQ-1 next cycle, so requester 0 wins first afterward.
REQ-023 SHALL re-grant a lone requester after BURST cycles (count restarts); no bubble.

Reset
REQ-024 SHALL on rst_n=0 asynchronously set state=IDLE, gnt_o=0, owner_o=0, busy_o=0, count=0, last_winner=NREQ-1, starve_o=0, all wait counters=0.
REQ-025 SHALL on reset mid-GRANT drop gnt_o immediately and ignore req_i until rst_n deasserts; the first grant after reset occurs no earlier than the cycle after the first rising edge with rst_n=1.

Configuration
REQ-026 SHALL with macro PATH_ARB_WATCHDOG_EN defined keep per-requester wait counters that increment while req_i[i]=1 and gnt_o[i]=0, clear otherwise, and set starve_o[i] sticky (cleared only by reset) when the counter reaches TIMEOUT.
REQ-027 SHALL without PATH_ARB_WATCHDOG_EN tie starve_o to 0, infer no wait counters, and keep the port list unchanged.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, GRANT) and the default-parameter constants in shared package path_arb_pkg.
REQ-029 SHALL implement round-robin selection in combinational sub-module rr_pick (inputs: req vector, last index; outputs: valid, winner index); the FSM, counters and watchdog stay in path_arbiter.

Verification
REQ-030 SHALL cover: from reset, req_i=4'b1010, ready_i=1 -> gnt_o=4'b0010 next cycle; after BURST=4 cycles -> 4'b1000 with no idle cycle.
REQ-031 SHALL cover: req_i=4'b1111 held, ready_i=1 -> grants rotate 0,1,2,3,0, each held exactly 4 cycles; one-hot check every cycle.
REQ-032 SHALL cover: only req_i[2]=1 for 10 cycles -> gnt_o=4'b0100 held continuously for all 10 cycles.
REQ-033 SHALL cover: owner 1 granted, ready_i=0 in cycle 2 -> gnt_o=0 next cycle, busy_o=0; ready_i=1 with req_i=4'b0011 -> next grant to requester 0 (searched from 2 with wrap, only 0 and 1 pending).
REQ-034 SHALL cover: flush_i=1 mid-grant to requester 3 with req_i=4'b1001 -> gnt_o=0 next cycle, then requester 0 granted; rst_n pulsed mid-grant -> gnt_o=0 asynchronously.
REQ-035 SHALL cover with PATH_ARB_WATCHDOG_EN and TIMEOUT=8: ready_i=0, req_i[0]=1 for 8 cycles -> starve_o[0]=1 and it stays 1 after req_i drops; without the macro, same stimulus -> starve_o=0.
